// File: rtl/operand_forward.sv
// Operand stage behind a registered-read register file: patches in writes the file has not yet exposed.
// Optional build macro OPERAND_FORWARD_X0_ZERO_EN forces operands sourced from x0 to zero.
module operand_forward #(
   parameter int XLEN        = 32,
   parameter int ADDR_BITS   = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clk_enable,
   input  logic                   flush,
   input  logic                   valid_si,
   input  logic [4:0]             rs1_si,
   input  logic [4:0]             rs2_si,
   input  logic [XLEN-1:0]        reg_a,
   input  logic [XLEN-1:0]        reg_b,
   input  logic                   wb_we,
   input  logic [4:0]             wb_rd,
   input  logic [XLEN-1:0]        wb_data,
   output logic [XLEN-1:0]        op_a,
   output logic [XLEN-1:0]        op_b,
   output logic                   valid_s2,
   output logic                   fwd_a,
   output logic                   fwd_b,
   output logic [COUNT_WIDTH-1:0] fwd_count
);

   logic                   eff_we_s;
   logic                   unused_addr_hi_s;
   logic [1:0]             fwd_inc_s;
   logic [COUNT_WIDTH:0]   count_sum_s;

   logic                   valid_s1_q,  valid_s1_d;
   logic [ADDR_BITS-1:0]   rs1_idx_q,   rs1_idx_d;
   logic [ADDR_BITS-1:0]   rs2_idx_q,   rs2_idx_d;
   logic                   pend_v_q,    pend_v_d;
   logic [ADDR_BITS-1:0]   pend_idx_q,  pend_idx_d;
   logic [XLEN-1:0]        pend_data_q, pend_data_d;
`ifdef OPERAND_FORWARD_X0_ZERO_EN
   logic                   rs1_x0_q,    rs1_x0_d;
   logic                   rs2_x0_q,    rs2_x0_d;
`endif
   logic [XLEN-1:0]        op_a_q,      op_a_d;
   logic [XLEN-1:0]        op_b_q,      op_b_d;
   logic                   fwd_a_q,     fwd_a_d;
   logic                   fwd_b_q,     fwd_b_d;
   logic                   valid_s2_q,  valid_s2_d;
   logic [COUNT_WIDTH-1:0] fwd_count_q, fwd_count_d;

   // Priority pick for one operand: live write port, then pending write, then file data.
   function automatic logic [XLEN:0] pick_operand(
      input logic [ADDR_BITS-1:0] rs_idx,
      input logic [XLEN-1:0]      file_data,
      input logic                 live_we,
      input logic [ADDR_BITS-1:0] live_idx,
      input logic [XLEN-1:0]      live_data,
      input logic                 pend_we,
      input logic [ADDR_BITS-1:0] pend_idx,
      input logic [XLEN-1:0]      pend_data
   );
      logic [XLEN:0] res;
      if (live_we && (live_idx == rs_idx)) begin
         res = {1'b1, live_data};
      end else if (pend_we && (pend_idx == rs_idx)) begin
         res = {1'b1, pend_data};
      end else begin
         res = {1'b0, file_data};
      end
      return res;
   endfunction

   assign eff_we_s = wb_we & (wb_rd != 5'd0);
   // Only the low ADDR_BITS of a source address take part in matching.
   assign unused_addr_hi_s = ^{rs1_si >> ADDR_BITS, rs2_si >> ADDR_BITS};

   // Next-state for the s1 capture, operand selection and forward counter.
   always_comb begin
      valid_s1_d  = valid_si & ~flush;
      rs1_idx_d   = rs1_si[ADDR_BITS-1:0];
      rs2_idx_d   = rs2_si[ADDR_BITS-1:0];
      pend_v_d    = eff_we_s;
      pend_idx_d  = wb_rd[ADDR_BITS-1:0];
      pend_data_d = wb_data;
`ifdef OPERAND_FORWARD_X0_ZERO_EN
      rs1_x0_d    = (rs1_si == 5'd0);
      rs2_x0_d    = (rs2_si == 5'd0);
`endif

      {fwd_a_d, op_a_d} = pick_operand(rs1_idx_q, reg_a, eff_we_s, wb_rd[ADDR_BITS-1:0], wb_data,
                                       pend_v_q, pend_idx_q, pend_data_q);
      {fwd_b_d, op_b_d} = pick_operand(rs2_idx_q, reg_b, eff_we_s, wb_rd[ADDR_BITS-1:0], wb_data,
                                       pend_v_q, pend_idx_q, pend_data_q);
`ifdef OPERAND_FORWARD_X0_ZERO_EN
      if (rs1_x0_q) begin
         op_a_d  = {XLEN{1'b0}};
         fwd_a_d = 1'b0;
      end else begin
         op_a_d  = op_a_d;
         fwd_a_d = fwd_a_d;
      end
      if (rs2_x0_q) begin
         op_b_d  = {XLEN{1'b0}};
         fwd_b_d = 1'b0;
      end else begin
         op_b_d  = op_b_d;
         fwd_b_d = fwd_b_d;
      end
`endif

      valid_s2_d  = valid_s1_q & ~flush;
      fwd_inc_s   = {1'b0, fwd_a_d} + {1'b0, fwd_b_d};
      count_sum_s = {1'b0, fwd_count_q} + {{(COUNT_WIDTH-1){1'b0}}, fwd_inc_s};
      // The carry-out bit doubles as the saturation flag.
      if (!valid_s2_d) begin
         fwd_count_d = fwd_count_q;
      end else if (count_sum_s[COUNT_WIDTH]) begin
         fwd_count_d = {COUNT_WIDTH{1'b1}};
      end else begin
         fwd_count_d = count_sum_s[COUNT_WIDTH-1:0];
      end
   end

   // Pipeline and counter registers; everything holds while clk_enable is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_s1_q  <= 1'b0;
         rs1_idx_q   <= {ADDR_BITS{1'b0}};
         rs2_idx_q   <= {ADDR_BITS{1'b0}};
         pend_v_q    <= 1'b0;
         pend_idx_q  <= {ADDR_BITS{1'b0}};
         pend_data_q <= {XLEN{1'b0}};
`ifdef OPERAND_FORWARD_X0_ZERO_EN
         rs1_x0_q    <= 1'b0;
         rs2_x0_q    <= 1'b0;
`endif
         op_a_q      <= {XLEN{1'b0}};
         op_b_q      <= {XLEN{1'b0}};
         fwd_a_q     <= 1'b0;
         fwd_b_q     <= 1'b0;
         valid_s2_q  <= 1'b0;
         fwd_count_q <= {COUNT_WIDTH{1'b0}};
      end else if (clk_enable) begin
         valid_s1_q  <= valid_s1_d;
         rs1_idx_q   <= rs1_idx_d;
         rs2_idx_q   <= rs2_idx_d;
         pend_v_q    <= pend_v_d;
         pend_idx_q  <= pend_idx_d;
         pend_data_q <= pend_data_d;
`ifdef OPERAND_FORWARD_X0_ZERO_EN
         rs1_x0_q    <= rs1_x0_d;
         rs2_x0_q    <= rs2_x0_d;
`endif
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         valid_s2_q  <= valid_s2_d;
         fwd_count_q <= fwd_count_d;
      end
   end

   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign fwd_a     = fwd_a_q;
   assign fwd_b     = fwd_b_q;
   assign valid_s2  = valid_s2_q;
   assign fwd_count = fwd_count_q;

endmodule
